// File: rtl/neuron_lut_pkg.sv
// Shared types and sizing helpers for the reloadable truth-table neuron.
// Default geometry matches the generated layer neurons (8-bit address, 2-bit entries).
package neuron_lut_pkg;

   localparam int unsigned DEF_IN_BITS      = 8;
   localparam int unsigned DEF_OUT_BITS     = 2;
   localparam int unsigned DEF_WORD_ENTRIES = 8;

   function automatic int unsigned calc_num_words(input int unsigned in_bits,
                                                  input int unsigned word_entries);
      if (word_entries == 0) return 1;
      return (32'd1 << in_bits) / word_entries;
   endfunction

   function automatic int unsigned calc_cnt_w(input int unsigned num_words);
      return (num_words > 1) ? $clog2(num_words) : 1;
   endfunction

   function automatic bit entries_divide(input int unsigned in_bits,
                                         input int unsigned word_entries);
      return (word_entries != 0) && (((32'd1 << in_bits) % word_entries) == 0);
   endfunction

   localparam int unsigned NUM_WORDS = calc_num_words(DEF_IN_BITS, DEF_WORD_ENTRIES);
   localparam int unsigned CNT_W     = calc_cnt_w(NUM_WORDS);
   localparam int unsigned CFG_W     = DEF_OUT_BITS * DEF_WORD_ENTRIES;
   localparam bit          DEF_OK    = entries_divide(DEF_IN_BITS, DEF_WORD_ENTRIES);

   typedef enum logic [1:0] {
      StIdle,
      StLoad,
      StActive
   } state_e;

endpackage

// File: rtl/lut_table_ram.sv
// Distributed-RAM truth table: one wide word write port, one registered read port.
// The read register can be cleared so the neuron output reads zero while inactive.
module lut_table_ram
   import neuron_lut_pkg::*;
#(
   parameter int unsigned IN_BITS      = DEF_IN_BITS,
   parameter int unsigned OUT_BITS     = DEF_OUT_BITS,
   parameter int unsigned WORD_ENTRIES = DEF_WORD_ENTRIES
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic                             we,
   input  logic [IN_BITS-1:0]               waddr,
   input  logic [OUT_BITS*WORD_ENTRIES-1:0] wdata,
   input  logic                             re,
   input  logic                             rclr,
   input  logic [IN_BITS-1:0]               raddr,
   output logic [OUT_BITS-1:0]              rdata
);

   localparam int unsigned Depth = 32'd1 << IN_BITS;

   logic [OUT_BITS-1:0] mem [Depth];
   logic [OUT_BITS-1:0] rdata_q;

   // Contents are deliberately not reset; only a completed load makes them visible.
   always_ff @(posedge clk) begin
      if (we) begin
         for (int i = 0; i < int'(WORD_ENTRIES); i++) begin
            mem[waddr + IN_BITS'(i)] <= wdata[i*OUT_BITS +: OUT_BITS];
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rdata_q <= '0;
      end else if (rclr) begin
         rdata_q <= '0;
      end else if (re) begin
         rdata_q <= mem[raddr];
      end
   end

   assign rdata = rdata_q;

endmodule

// File: rtl/neuron_lut_loader.sv
// Runtime-reloadable truth-table neuron: streams packed table words in over a
// ready/valid port, then serves one-cycle registered lookups once the table is complete.
module neuron_lut_loader
   import neuron_lut_pkg::*;
#(
   parameter int unsigned IN_BITS      = DEF_IN_BITS,
   parameter int unsigned OUT_BITS     = DEF_OUT_BITS,
   parameter int unsigned WORD_ENTRIES = DEF_WORD_ENTRIES
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic                             cfg_start,
   input  logic                             cfg_valid,
   output logic                             cfg_ready,
   input  logic [OUT_BITS*WORD_ENTRIES-1:0] cfg_data,
   output logic                             cfg_done,
   output logic                             active,
   input  logic [IN_BITS-1:0]               lut_in,
   input  logic                             lut_in_valid,
   output logic [OUT_BITS-1:0]              lut_out,
   output logic                             lut_out_valid
);

   localparam int unsigned      NumWords   = calc_num_words(IN_BITS, WORD_ENTRIES);
   localparam int unsigned      CntW       = calc_cnt_w(NumWords);
   localparam logic [CntW-1:0]  LastCnt    = CntW'(NumWords - 1);
   localparam logic [IN_BITS-1:0] WordStride = IN_BITS'(WORD_ENTRIES);

   if (!entries_divide(IN_BITS, WORD_ENTRIES)) begin : gen_cfg_check
      $error("neuron_lut_loader: WORD_ENTRIES must divide 2**IN_BITS");
   end

   state_e          state_q, state_d;
   logic [CntW-1:0] cnt_q, cnt_d;
   logic            cfg_done_q, lut_valid_q;
   logic            hs, last_hs, rd_en;
   logic [IN_BITS-1:0] waddr;

   assign hs      = cfg_valid & cfg_ready;
   assign last_hs = hs & (cnt_q == LastCnt);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   // A start pulse overrides everything, including the final handshake of a load.
   always_comb begin
      state_d = state_q;
      if (cfg_start) begin
         state_d = StLoad;
      end else if ((state_q == StLoad) && last_hs) begin
         state_d = StActive;
      end
   end

   always_comb begin
      cfg_ready = 1'b0;
      active    = 1'b0;
      unique case (state_q)
         StLoad:   cfg_ready = ~cfg_start;
         StActive: active    = 1'b1;
         default:  ;
      endcase
   end

   always_comb begin
      cnt_d = cnt_q;
      if (cfg_start) begin
         cnt_d = '0;
      end else if (hs) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q       <= '0;
         cfg_done_q  <= 1'b0;
         lut_valid_q <= 1'b0;
      end else begin
         cnt_q       <= cnt_d;
         cfg_done_q  <= last_hs;
         lut_valid_q <= rd_en;
      end
   end

   assign rd_en = active & lut_in_valid;
   assign waddr = IN_BITS'(cnt_q) * WordStride;

   lut_table_ram #(
      .IN_BITS      (IN_BITS),
      .OUT_BITS     (OUT_BITS),
      .WORD_ENTRIES (WORD_ENTRIES)
   ) u_ram (
      .clk   (clk),
      .rst   (rst),
      .we    (hs),
      .waddr (waddr),
      .wdata (cfg_data),
      .re    (rd_en),
      .rclr  (~active),
      .raddr (lut_in),
      .rdata (lut_out)
   );

   assign cfg_done      = cfg_done_q;
   assign lut_out_valid = lut_valid_q;

endmodule

// File: tb/tb_neuron_lut_loader.sv
// Self-checking bench for neuron_lut_loader: loads tables, sweeps lookups through a
// scoreboard and exercises restart, bursty and asynchronous-reset corner cases.
module tb_neuron_lut_loader;

   localparam int unsigned IN_BITS      = 8;
   localparam int unsigned OUT_BITS     = 2;
   localparam int unsigned WORD_ENTRIES = 8;

   logic        clk = 1'b0;
   logic        rst;
   logic        cfg_start, cfg_valid, cfg_ready, cfg_done, active;
   logic [15:0] cfg_data;
   logic [7:0]  lut_in;
   logic        lut_in_valid, lut_out_valid;
   logic [1:0]  lut_out;

   typedef struct {
      logic       vld;
      logic [1:0] out;
   } exp_t;

   typedef struct {
      logic [7:0] addr;
      logic [1:0] out;
   } vec_t;

   exp_t       sb_q[$];
   logic [1:0] ref_mem [256];
   vec_t       vecs [8];
   int         n_chk = 0;
   int         n_pass = 0;
   int         done_cnt = 0;

   always #5 clk = ~clk;

   neuron_lut_loader #(
      .IN_BITS      (IN_BITS),
      .OUT_BITS     (OUT_BITS),
      .WORD_ENTRIES (WORD_ENTRIES)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .cfg_start     (cfg_start),
      .cfg_valid     (cfg_valid),
      .cfg_ready     (cfg_ready),
      .cfg_data      (cfg_data),
      .cfg_done      (cfg_done),
      .active        (active),
      .lut_in        (lut_in),
      .lut_in_valid  (lut_in_valid),
      .lut_out       (lut_out),
      .lut_out_valid (lut_out_valid)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Scoreboard: a lookup driven before an edge is compared just after that edge.
   always @(posedge clk) begin
      exp_t e;
      #1;
      if (cfg_done === 1'b1) done_cnt++;
      if (sb_q.size() > 0) begin
         e = sb_q.pop_front();
         chk("lut_out_valid", 32'(lut_out_valid), 32'(e.vld));
         chk("lut_out", 32'(lut_out), 32'(e.out));
      end else begin
         chk("idle_out_valid", 32'(lut_out_valid), 32'd0);
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1);
   end

   // Tasks start just after a falling edge and return at the next falling edge.
   task automatic lookup(input logic [7:0] a, input logic ev, input logic [1:0] eo);
      exp_t e;
      lut_in       = a;
      lut_in_valid = 1'b1;
      e.vld        = ev;
      e.out        = eo;
      sb_q.push_back(e);
      @(negedge clk);
      lut_in_valid = 1'b0;
   endtask

   task automatic verify_all();
      for (int a = 0; a < 256; a++) lookup(8'(a), 1'b1, ref_mem[a]);
   endtask

   task automatic do_load(input int pattern, input int nwords, input int gap_max,
                          input logic start_valid);
      logic [15:0] w;
      int          d0;
      d0        = done_cnt;
      cfg_start = 1'b1;
      cfg_valid = start_valid;
      cfg_data  = 16'h5A5A;
      #1 chk("ready_on_start", 32'(cfg_ready), 32'd0);
      @(negedge clk);
      cfg_start = 1'b0;
      cfg_valid = 1'b0;
      chk("active_after_start", 32'(active), 32'd0);
      for (int k = 0; k < nwords; k++) begin
         repeat ($urandom_range(gap_max, 0)) @(negedge clk);
         case (pattern)
            0:       w = {8{k[1:0]}};
            1:       w = 16'hAAAA;
            default: w = 16'($urandom);
         endcase
         cfg_valid = 1'b1;
         cfg_data  = w;
         #1 chk("ready_in_load", 32'(cfg_ready), 32'd1);
         for (int i = 0; i < 8; i++) ref_mem[k*8 + i] = w[i*2 +: 2];
         @(negedge clk);
         cfg_valid = 1'b0;
         if (k == 30) chk("no_early_active", 32'(active), 32'd0);
      end
      if (nwords == 32) begin
         chk("cfg_done_pulse", 32'(cfg_done), 32'd1);
         chk("active_set", 32'(active), 32'd1);
      end
      chk("done_count", 32'(done_cnt - d0), (nwords == 32) ? 32'd1 : 32'd0);
   endtask

   initial begin
      vecs[0] = '{8'h0C, 2'b01};
      vecs[1] = '{8'hFF, 2'b11};
      vecs[2] = '{8'h00, 2'b00};
      vecs[3] = '{8'h08, 2'b01};
      vecs[4] = '{8'h17, 2'b10};
      vecs[5] = '{8'h1F, 2'b11};
      vecs[6] = '{8'h20, 2'b00};
      vecs[7] = '{8'hF8, 2'b11};

      rst          = 1'b1;
      cfg_start    = 1'b0;
      cfg_valid    = 1'b0;
      cfg_data     = '0;
      lut_in       = '0;
      lut_in_valid = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_cfg_ready", 32'(cfg_ready), 32'd0);
      chk("rst_cfg_done", 32'(cfg_done), 32'd0);
      chk("rst_active", 32'(active), 32'd0);
      chk("rst_lut_out", 32'(lut_out), 32'd0);
      chk("rst_lut_out_valid", 32'(lut_out_valid), 32'd0);
      rst = 1'b0;
      @(negedge clk);

      // Lookups before any load are rejected.
      lookup(8'h00, 1'b0, 2'b00);
      lookup(8'hFF, 1'b0, 2'b00);
      chk("idle_ready", 32'(cfg_ready), 32'd0);

      // Full load, entries = word index mod 4; first lookup in the cycle active rises.
      do_load(0, 32, 0, 1'b0);
      for (int v = 0; v < 8; v++) begin
         lookup(vecs[v].addr, 1'b1, vecs[v].out);
         if (v == 0) chk("done_one_cycle", 32'(cfg_done), 32'd0);
      end
      lut_in = 8'h00;
      @(negedge clk);
      chk("lut_out_hold", 32'(lut_out), 32'(vecs[7].out));
      chk("active_ready", 32'(cfg_ready), 32'd0);

      // Reload from ACTIVE with a constant pattern.
      do_load(1, 32, 0, 1'b0);
      verify_all();

      // Start with valid asserted, partial load, restart (again with valid), full load.
      do_load(2, 10, 0, 1'b1);
      lookup(8'h05, 1'b0, 2'b00);
      do_load(2, 32, 0, 1'b1);
      verify_all();

      // Bursty valid with random gaps.
      do_load(2, 32, 3, 1'b0);
      verify_all();

      // Asynchronous reset partway through a load.
      do_load(2, 20, 0, 1'b0);
      #2 rst = 1'b1;
      #1;
      chk("arst_cfg_ready", 32'(cfg_ready), 32'd0);
      chk("arst_cfg_done", 32'(cfg_done), 32'd0);
      chk("arst_active", 32'(active), 32'd0);
      chk("arst_lut_out", 32'(lut_out), 32'd0);
      chk("arst_lut_out_valid", 32'(lut_out_valid), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      lookup(8'h10, 1'b0, 2'b00);
      do_load(0, 32, 0, 1'b0);
      lookup(8'hFF, 1'b1, 2'b11);
      // Reset while a valid nonzero lookup result is on the output.
      #2 rst = 1'b1;
      #1;
      chk("arst2_lut_out", 32'(lut_out), 32'd0);
      chk("arst2_lut_out_valid", 32'(lut_out_valid), 32'd0);
      chk("arst2_active", 32'(active), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      lookup(8'hFF, 1'b0, 2'b00);

      repeat (2) @(negedge clk);
      chk("sb_drained", 32'(sb_q.size()), 32'd0);
      chk("total_done_pulses", 32'(done_cnt), 32'd5);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
